// File: rtl/word_fetcher.sv
// word_fetcher: grabs a random index, reads one word from a synchronous ROM and streams it
// character by character over valid/ready. Define WORD_FETCH_NO_REPEAT_EN to re-grab repeated indices.
module word_fetcher #(
    parameter int WORD_LEN  = 5,
    parameter int CHAR_W    = 8,
    parameter int NUM_WORDS = 100
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic                         grab_word,
    input  logic [6:0]                   random_num,
    output logic [6:0]                   rom_addr,
    input  logic [WORD_LEN*CHAR_W-1:0]   rom_data,
    output logic [CHAR_W-1:0]            char_out,
    output logic [2:0]                   char_idx,
    output logic                         char_valid,
    input  logic                         char_ready,
    output logic                         word_done,
    output logic                         busy,
    output logic                         range_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRAB,
        S_SETTLE,
        S_ADDR,
        S_READ,
        S_EMIT,
        S_DONE
    } state_e;

    localparam logic [2:0] LAST_IDX = 3'(WORD_LEN - 1);

    state_e                       state_q, state_d;
    logic [6:0]                   rom_addr_q, rom_addr_d;
    logic [WORD_LEN*CHAR_W-1:0]   word_q, word_d;
    logic [2:0]                   char_idx_q, char_idx_d;
    logic                         range_err_q, range_err_d;

    logic                         in_range;
    logic [6:0]                   index_calc;
    logic                         repeat_hit;

    assign in_range   = (random_num != 7'd0) && (int'(random_num) <= NUM_WORDS);
    assign index_calc = in_range ? (random_num - 7'd1) : 7'd0;

`ifdef WORD_FETCH_NO_REPEAT_EN
    logic [6:0] prev_idx_q, prev_idx_d;
    logic [1:0] regrab_q, regrab_d;

    // 7'h7F can never match a legal index, so the first word is always accepted.
    assign repeat_hit = (index_calc == prev_idx_q) && (regrab_q != 2'd3);

    always_comb begin
        prev_idx_d = prev_idx_q;
        regrab_d   = regrab_q;
        if ((state_q == S_IDLE) && start) begin
            regrab_d = 2'd0;
        end
        if (state_q == S_ADDR) begin
            if (repeat_hit) begin
                regrab_d = regrab_q + 2'd1;
            end else begin
                prev_idx_d = index_calc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_idx_q <= 7'h7F;
            regrab_q   <= 2'd0;
        end else begin
            prev_idx_q <= prev_idx_d;
            regrab_q   <= regrab_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        word_d      = word_q;
        char_idx_d  = char_idx_q;
        range_err_d = range_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_GRAB;
                    range_err_d = 1'b0;
                end
            end
            S_GRAB:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_ADDR;
            S_ADDR: begin
                rom_addr_d = index_calc;
                if (!in_range) begin
                    range_err_d = 1'b1;
                end
                state_d = repeat_hit ? S_GRAB : S_READ;
            end
            S_READ: begin
                word_d     = rom_data;
                char_idx_d = 3'd0;
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (char_ready) begin
                    if (char_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        char_idx_d = char_idx_q + 3'd1;
                    end
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, and the word register is cleared with the rest.
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= 7'd0;
            word_q      <= '0;
            char_idx_q  <= 3'd0;
            range_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            word_q      <= word_d;
            char_idx_q  <= char_idx_d;
            range_err_q <= range_err_d;
        end
    end

    // Character 0 sits in the MSBs of the ROM word.
    always_comb begin
        char_out = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (char_idx_q == 3'(i)) begin
                char_out = word_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
            end
        end
    end

    // The address is live during ADDR so the ROM samples it on the ADDR->READ edge.
    assign rom_addr   = (state_q == S_ADDR) ? index_calc : rom_addr_q;
    assign grab_word  = (state_q == S_GRAB);
    assign char_valid = (state_q == S_EMIT);
    assign word_done  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign char_idx   = char_idx_q;
    assign range_err  = range_err_q;

endmodule
